uart_msg_framer: RTL and testbench

UART_MSG_FRAMER -- requirements
Module: uart_msg_framer

---
 rtl/uart_pkg.sv | 29 ++
 rtl/msg_fifo.sv | 58 +++++
 rtl/uart_msg_framer.sv | 131 +++++++++++++
 tb/tb_uart_msg_framer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART message framer: FSM state encoding, request record
// and the default frame header.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_CMD,
      ST_ARG_HI,
      ST_ARG_LO,
      ST_CSUM,
      ST_GAP
   } state_t;

   localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [15:0] arg;
   } req_t;

   localparam int REQ_W = $bits(req_t);

   // Checksum covers the payload only; the header byte is excluded.
   function automatic logic [7:0] frame_csum(input req_t r);
      return r.cmd ^ r.arg[15:8] ^ r.arg[7:0];
   endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO with occupancy count; read data is presented combinationally
// from the head entry. Pushes while full and pops while empty are ignored.
module msg_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read after
   // being written, and an unreset array maps onto plain RAM/register files.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == COUNT_FULL);
   assign empty = (count == '0);

endmodule

// File: rtl/uart_msg_framer.sv
// Turns buffered {cmd, arg} requests into HEADER/cmd/arg_hi/arg_lo/csum byte
// frames for a uart_tx, with a fixed idle gap between frames.
module uart_msg_framer
   import uart_pkg::*;
#(
   parameter logic [7:0] HEADER     = DEFAULT_HEADER,
   parameter int         FIFO_DEPTH = 4,
   parameter int         GAP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [15:0] req_arg,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy,
   output logic        frame_done
);

   localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]   COUNT_FULL = CW'(FIFO_DEPTH);
   localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : GAP_W'(0);

   state_t           state;
   state_t           state_next;
   req_t             frame_q;
   req_t             req_in;
   logic [GAP_W-1:0] gap_cnt;
   logic             done_q;

   logic [REQ_W-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             fifo_push;
   logic             fifo_pop;
   logic             byte_xfer;
   logic             csum_xfer;

   assign req_in     = '{cmd: req_cmd, arg: req_arg};
   assign req_ready  = (fifo_count != COUNT_FULL);
   assign fifo_push  = req_valid && !fifo_full;
   assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
   assign byte_xfer  = byte_valid && byte_ready;
   assign csum_xfer  = (state == ST_CSUM) && byte_xfer;
   assign frame_done = done_q;

   msg_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (req_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Frame register, gap timer and the one-cycle completion pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_q <= '0;
         gap_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= csum_xfer;
         if (fifo_pop) frame_q <= req_t'(fifo_dout);
         if (csum_xfer)                              gap_cnt <= GAP_LOAD;
         else if (state == ST_GAP && gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
      end
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (!fifo_empty) state_next = ST_HDR;
         ST_HDR:    if (byte_xfer)   state_next = ST_CMD;
         ST_CMD:    if (byte_xfer)   state_next = ST_ARG_HI;
         ST_ARG_HI: if (byte_xfer)   state_next = ST_ARG_LO;
         ST_ARG_LO: if (byte_xfer)   state_next = ST_CSUM;
         ST_CSUM:   if (byte_xfer)   state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:    if (gap_cnt == '0) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      busy       = (state != ST_IDLE);
      case (state)
         ST_HDR: begin
            byte_valid = 1'b1;
            byte_data  = HEADER;
         end
         ST_CMD: begin
            byte_valid = 1'b1;
            byte_data  = frame_q.cmd;
         end
         ST_ARG_HI: begin
            byte_valid = 1'b1;
            byte_data  = frame_q.arg[15:8];
         end
         ST_ARG_LO: begin
            byte_valid = 1'b1;
            byte_data  = frame_q.arg[7:0];
         end
         ST_CSUM: begin
            byte_valid = 1'b1;
            byte_data  = frame_csum(frame_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_msg_framer.sv
// Scoreboard bench for uart_msg_framer: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every byte transfer.
module tb_uart_msg_framer;

   localparam int         GAP   = 16;
   localparam int         DEPTH = 4;
   localparam logic [7:0] HDR   = 8'hAA;

   typedef struct {
      logic [7:0] b;
      bit         last;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_cmd;
   logic [15:0] req_arg;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic        frame_done;

   int vectors;
   int miscompares;
   int br_mode;

   exp_t       exp_q[$];
   logic [7:0] seen_q[$];

   uart_msg_framer #(
      .HEADER     (HDR),
      .FIFO_DEPTH (DEPTH),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_arg    (req_arg),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a frame is the header, the payload bytes MSB first, and
   // the XOR of the payload bytes.
   task automatic push_frame(input logic [7:0] c, input logic [15:0] a);
      logic [7:0] bytes [5];
      bytes[0] = HDR;
      bytes[1] = c;
      bytes[2] = a[15:8];
      bytes[3] = a[7:0];
      bytes[4] = c ^ a[15:8] ^ a[7:0];
      for (int k = 0; k < 5; k++) exp_q.push_back('{b: bytes[k], last: (k == 4)});
   endtask

   task automatic send(input logic [7:0] c, input logic [15:0] a, output bit ok);
      bit acc;
      req_valid = 1'b1;
      req_cmd   = c;
      req_arg   = a;
      ok        = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         acc = req_ready;
         tick();
         if (acc) ok = 1'b1;
      end
      if (ok) push_frame(c, a);
      else    check("req_accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         tick();
         n++;
      end
      check("drain_within_bound", 32'(n < 5000), 32'd1);
   endtask

   task automatic check_seen(input int base, input logic [39:0] want);
      check("frame_len", 32'(seen_q.size() - base), 32'd5);
      for (int k = 0; k < 5; k++)
         check("frame_byte", 32'(seen_q[base + k]), 32'(want[39 - 8*k -: 8]));
   endtask

   // byte_ready driver; updates land 2 time units after the edge so mode
   // changes made by the stimulus at edge+1 take effect for the next edge.
   initial begin : ready_driver
      int cyc;
      cyc        = 0;
      byte_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         case (br_mode)
            0:       byte_ready = 1'b0;
            1:       byte_ready = 1'b1;
            2:       byte_ready = (cyc % 10 == 0);
            default: byte_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      logic [7:0] prev_data;
      bit         prev_stall;
      bit         expect_done;
      bit         gap_armed;
      int         gap_count;
      exp_t       e;
      prev_data   = '0;
      prev_stall  = 1'b0;
      expect_done = 1'b0;
      gap_armed   = 1'b0;
      gap_count   = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            prev_stall  = 1'b0;
            expect_done = 1'b0;
            gap_armed   = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(byte_valid), 32'd1);
               check("hold_data", 32'(byte_data), 32'(prev_data));
            end
            if (!byte_valid) check("idle_data_zero", 32'(byte_data), 32'd0);
            check("frame_done", 32'(frame_done), 32'(expect_done));
            expect_done = 1'b0;
            if (frame_done) begin
               gap_armed = 1'b1;
               gap_count = 0;
            end
            if (gap_armed && busy && !byte_valid) gap_count++;
            if (gap_armed && byte_valid) begin
               check("gap_cycles", 32'(gap_count), 32'(GAP));
               gap_armed = 1'b0;
            end
            if (byte_valid && byte_ready) begin
               seen_q.push_back(byte_data);
               check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("byte_data", 32'(byte_data), 32'(e.b));
                  expect_done = e.last;
               end
            end
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
         end
      end
   end

   initial begin : stimulus
      bit          ok;
      bit          acc;
      int          base;
      int          accepted;
      logic [7:0]  c;
      logic [15:0] a;

      vectors     = 0;
      miscompares = 0;
      br_mode     = 0;
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_cmd     = '0;
      req_arg     = '0;

      repeat (3) tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_byte_valid", 32'(byte_valid), 32'd0);
      check("rst_byte_data", 32'(byte_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b1;
      tick();

      // Single frame, receiver always ready; also first-byte latency.
      br_mode = 1;
      base    = seen_q.size();
      send(8'h12, 16'h3456, ok);
      req_valid = 1'b0;
      check("lat_idle_after_accept", 32'(byte_valid), 32'd0);
      tick();
      check("lat_hdr_valid", 32'(byte_valid), 32'd1);
      check("lat_hdr_data", 32'(byte_data), 32'(HDR));
      drain();
      check_seen(base, {8'hAA, 8'h12, 8'h34, 8'h56, 8'h70});

      // Same frame with a sparse ready; monitor checks stability while stalled.
      br_mode = 2;
      base    = seen_q.size();
      send(8'h12, 16'h3456, ok);
      req_valid = 1'b0;
      drain();
      check_seen(base, {8'hAA, 8'h12, 8'h34, 8'h56, 8'h70});

      // Checksum that cancels to zero.
      br_mode = 3;
      base    = seen_q.size();
      send(8'hFF, 16'h00FF, ok);
      req_valid = 1'b0;
      drain();
      check_seen(base, {8'hAA, 8'hFF, 8'h00, 8'hFF, 8'h00});

      // Back-to-back requests against a stalled receiver fill the buffer.
      br_mode   = 0;
      accepted  = 0;
      c         = 8'($urandom);
      a         = 16'($urandom);
      req_valid = 1'b1;
      req_cmd   = c;
      req_arg   = a;
      for (int i = 0; i < 6; i++) begin
         acc = req_ready;
         tick();
         if (acc) begin
            push_frame(c, a);
            accepted++;
            c       = 8'($urandom);
            a       = 16'($urandom);
            req_cmd = c;
            req_arg = a;
         end
      end
      req_valid = 1'b0;
      check("accepted_until_full", 32'(accepted), 32'd5);
      check("ready_low_when_full", 32'(req_ready), 32'd0);
      br_mode = 3;
      drain();

      // Two consecutive frames; the monitor measures the inter-frame gap.
      br_mode = 1;
      send(8'h01, 16'h0203, ok);
      send(8'h04, 16'h0506, ok);
      req_valid = 1'b0;
      drain();

      // Reset while the third byte of a frame is pending, two requests queued.
      br_mode = 0;
      send(8'h21, 16'h2223, ok);
      send(8'h31, 16'h3233, ok);
      send(8'h41, 16'h4243, ok);
      req_valid = 1'b0;
      br_mode   = 1;
      tick();
      tick();
      br_mode = 0;
      rst     = 1'b0;
      tick();
      check("abort_byte_valid", 32'(byte_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_byte_data", 32'(byte_data), 32'd0);
      rst     = 1'b1;
      base    = seen_q.size();
      br_mode = 1;
      repeat (30) tick();
      check("abort_no_more_bytes", 32'(seen_q.size() - base), 32'd0);
      check("abort_stays_idle", 32'(busy), 32'd0);

      // Randomized traffic with random receiver back-pressure.
      br_mode = 3;
      for (int n = 0; n < 40; n++) begin
         int idle;
         idle = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
         req_valid = 1'b0;
         repeat (idle) tick();
         send(8'($urandom), 16'($urandom), ok);
      end
      req_valid = 1'b0;
      drain();
      check("final_busy", 32'(busy), 32'd0);
      check("final_ready", 32'(req_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
